// File: rtl/cmp_seq_pkg.sv
// -----------------------------------------------------------------------------
// cmp_seq_pkg
// Shared types and constants for the byte-serial comparator controller.
//   state_e      : controller FSM encoding (IDLE/RUN/DONE)
//   cascade_t    : {l,e,g} cascade triple carried between byte steps
//   CASCADE_INIT : cascade value before the first byte ("equal so far")
//   SIGN_FLIP    : XOR mask that maps a two's-complement top byte onto
//                  unsigned order
// -----------------------------------------------------------------------------
package cmp_seq_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_e;

   typedef struct packed {
      logic l;
      logic e;
      logic g;
   } cascade_t;

   localparam logic [2:0] CASCADE_INIT = 3'b010;
   localparam logic [7:0] SIGN_FLIP    = 8'h80;

endpackage

// File: rtl/cmp8_cascade.sv
// -----------------------------------------------------------------------------
// cmp8_cascade
// Combinational 8-bit cascadable magnitude comparator.
//   a, b      : byte operands
//   l, e, g   : cascade inputs (result of less-significant bytes)
//   lt, eq, gt: this byte decides when it differs, else cascade passes through
// -----------------------------------------------------------------------------
module cmp8_cascade (
   input  logic [7:0] a,
   input  logic [7:0] b,
   input  logic       l,
   input  logic       e,
   input  logic       g,
   output logic       lt,
   output logic       eq,
   output logic       gt
);

   always_comb begin
      lt = l;
      eq = e;
      gt = g;
      if (a > b) begin
         lt = 1'b0;
         eq = 1'b0;
         gt = 1'b1;
      end else if (a < b) begin
         lt = 1'b1;
         eq = 1'b0;
         gt = 1'b0;
      end
   end

endmodule

// File: rtl/cmp_seq_ctrl.sv
// -----------------------------------------------------------------------------
// cmp_seq_ctrl
// Compares two NBYTES-wide operands one byte per cycle, LSB first, through a
// single shared cmp8_cascade. Each byte result is registered and fed back as
// the cascade input of the next byte, so the most-significant differing byte
// has the final say.
//
// Ports
//   clk, rst_n           : clock, asynchronous active-low reset
//   in_valid / in_ready  : request handshake; a/b sampled on accept
//   a, b                 : operands (8*NBYTES bits)
//   out_valid / out_ready: result handshake; result held until accepted
//   lt, eq, gt           : one-hot compare result, zero while out_valid is low
//   busy                 : high in RUN and DONE
//
// Build option
//   CMP_SEQ_SIGNED_EN    : when defined, operands are two's complement; the
//                          top byte of both operands is XORed with 8'h80
//                          before it reaches the comparator.
// -----------------------------------------------------------------------------
module cmp_seq_ctrl
   import cmp_seq_pkg::*;
#(
   parameter int NBYTES = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [8*NBYTES-1:0]   a,
   input  logic [8*NBYTES-1:0]   b,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic                  lt,
   output logic                  eq,
   output logic                  gt,
   output logic                  busy
);

   localparam int W  = 8 * NBYTES;
   localparam int IW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
   localparam logic [IW-1:0] LAST_IDX = IW'(NBYTES - 1);

   state_e         state_q, state_d;
   logic [W-1:0]   a_q, a_d;
   logic [W-1:0]   b_q, b_d;
   logic [IW-1:0]  idx_q, idx_d;
   cascade_t       cas_q, cas_d;

   logic [7:0]     byte_a, byte_b;
   logic           c_lt, c_eq, c_gt;

   // Byte select from the captured operands (never from the live inputs).
   always_comb begin
      byte_a = a_q[8*idx_q +: 8];
      byte_b = b_q[8*idx_q +: 8];
`ifdef CMP_SEQ_SIGNED_EN
      // Flipping the sign bit of the top byte maps two's-complement order
      // onto unsigned order; lower bytes are already unsigned magnitudes.
      if (idx_q == LAST_IDX) begin
         byte_a = byte_a ^ SIGN_FLIP;
         byte_b = byte_b ^ SIGN_FLIP;
      end
`endif
   end

   cmp8_cascade u_cmp8 (
      .a  (byte_a),
      .b  (byte_b),
      .l  (cas_q.l),
      .e  (cas_q.e),
      .g  (cas_q.g),
      .lt (c_lt),
      .eq (c_eq),
      .gt (c_gt)
   );

   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      idx_d   = idx_q;
      cas_d   = cas_q;
      unique case (state_q)
         ST_IDLE: begin
            if (in_valid) begin
               a_d     = a;
               b_d     = b;
               idx_d   = '0;
               cas_d   = cascade_t'(CASCADE_INIT);
               state_d = ST_RUN;
            end
         end
         ST_RUN: begin
            cas_d = '{l: c_lt, e: c_eq, g: c_gt};
            if (idx_q == LAST_IDX) begin
               state_d = ST_DONE;
            end else begin
               idx_d = idx_q + 1'b1;
            end
         end
         ST_DONE: begin
            if (out_ready) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         a_q     <= '0;
         b_q     <= '0;
         idx_q   <= '0;
         cas_q   <= cascade_t'(CASCADE_INIT);
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         idx_q   <= idx_d;
         cas_q   <= cas_d;
      end
   end

   // Result outputs are gated by DONE so they read zero outside a valid
   // result, even though the cascade register idles at "equal".
   always_comb begin
      in_ready  = (state_q == ST_IDLE);
      out_valid = (state_q == ST_DONE);
      busy      = (state_q == ST_RUN) || (state_q == ST_DONE);
      lt        = out_valid & cas_q.l;
      eq        = out_valid & cas_q.e;
      gt        = out_valid & cas_q.g;
   end

endmodule

// File: tb/tb_cmp_seq_ctrl.sv
module tb_cmp_seq_ctrl;

   localparam int NBYTES = 4;
   localparam int W      = 8 * NBYTES;

   logic         clk = 1'b0;
   logic         rst_n = 1'b1;
   logic         in_valid = 1'b0;
   logic         out_ready = 1'b1;
   logic [W-1:0] a = '0;
   logic [W-1:0] b = '0;
   logic         in_ready, out_valid, lt, eq, gt, busy;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   cmp_seq_ctrl #(.NBYTES(NBYTES)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .lt        (lt),
      .eq        (eq),
      .gt        (gt),
      .busy      (busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Reference: whole-word comparison, returned as {lt,eq,gt}.
   function automatic logic [2:0] ref_cmp(input logic [W-1:0] x, input logic [W-1:0] y);
`ifdef CMP_SEQ_SIGNED_EN
      if ($signed(x) < $signed(y)) return 3'b100;
      if ($signed(x) > $signed(y)) return 3'b001;
`else
      if (x < y) return 3'b100;
      if (x > y) return 3'b001;
`endif
      return 3'b010;
   endfunction

   // Operand pairs biased toward equal / single-byte-different cases.
   task automatic pick_ops(output logic [W-1:0] x, output logic [W-1:0] y);
      int mode;
      int k;
      logic [7:0] nb;
      for (int i = 0; i < NBYTES; i++) x[8*i +: 8] = 8'($urandom);
      y    = x;
      mode = $urandom_range(0, 3);
      if (mode == 0) begin
         for (int i = 0; i < NBYTES; i++) y[8*i +: 8] = 8'($urandom);
      end else if (mode >= 2) begin
         k  = $urandom_range(0, NBYTES - 1);
         nb = 8'($urandom);
         y[8*k +: 8] = nb;
      end
   endtask

   // Issue one request from IDLE; lat counts the accept edge as edge 1 and
   // stops at the edge after which out_valid is seen. Returns at the negedge
   // where out_valid is first high (or after a bounded wait).
   task automatic run_req(input logic [W-1:0] x, input logic [W-1:0] y,
                          output logic [2:0] res, output int lat);
      @(negedge clk);
      a = x; b = y; in_valid = 1'b1;
      @(posedge clk);
      lat = 1;
      @(negedge clk);
      in_valid = 1'b0;
      while (!out_valid && lat < 50) begin
         @(posedge clk);
         lat++;
         @(negedge clk);
      end
      res = {lt, eq, gt};
   endtask

   task automatic test_reset();
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if ({in_ready, out_valid, lt, eq, gt, busy} !== 6'b100000) begin
         errors++;
         $display("FAIL reset_async got %b exp 100000", {in_ready, out_valid, lt, eq, gt, busy});
      end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      checks++;
      if ({in_ready, out_valid, lt, eq, gt, busy} !== 6'b100000) begin
         errors++;
         $display("FAIL reset_release got %b exp 100000", {in_ready, out_valid, lt, eq, gt, busy});
      end
   endtask

   task automatic test_directed();
      logic [W-1:0] va [3] = '{32'h12345678, 32'hA0000001, 32'hCAFEBABE};
      logic [W-1:0] vb [3] = '{32'h12345679, 32'h9FFFFFFF, 32'hCAFEBABE};
      logic [2:0]   ve [3] = '{3'b100, 3'b001, 3'b010};
      logic [2:0]   res;
      int           lat;
      out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         run_req(va[i], vb[i], res, lat);
         checks++;
         if (res !== ve[i]) begin
            errors++;
            $display("FAIL directed_%0d result got %b exp %b", i, res, ve[i]);
         end
         checks++;
         if (lat != NBYTES + 1) begin
            errors++;
            $display("FAIL directed_%0d latency got %0d exp %0d", i, lat, NBYTES + 1);
         end
      end
   endtask

   task automatic test_signed_vector();
      logic [2:0] res;
      logic [2:0] exp;
      int         lat;
`ifdef CMP_SEQ_SIGNED_EN
      exp = 3'b100;
`else
      exp = 3'b001;
`endif
      run_req(32'hFFFFFFFF, 32'h00000001, res, lat);
      checks++;
      if (res !== exp) begin
         errors++;
         $display("FAIL signed_vector result got %b exp %b", res, exp);
      end
   endtask

   task automatic test_back_to_back();
      logic [W-1:0] qa[$];
      logic [W-1:0] qb[$];
      int           acc[$];
      int           n_res = 0;
      logic [2:0]   exp;
      logic [W-1:0] x, y;
      out_ready = 1'b1;
      pick_ops(x, y);
      a = x; b = y; in_valid = 1'b1;
      for (int c = 0; c < 80 && n_res < 4; c++) begin
         @(negedge clk);
         if (out_valid) begin
            checks++;
            if (qa.size() == 0) begin
               errors++;
               $display("FAIL b2b_unexpected_result got 1 exp 0");
            end else begin
               exp = ref_cmp(qa.pop_front(), qb.pop_front());
               if ({lt, eq, gt} !== exp) begin
                  errors++;
                  $display("FAIL b2b_result_%0d got %b exp %b", n_res, {lt, eq, gt}, exp);
               end
            end
            n_res++;
         end
         if (in_ready && in_valid) begin
            qa.push_back(a); qb.push_back(b); acc.push_back(cyc);
         end else if (acc.size() >= 4) begin
            in_valid = 1'b0;
         end else begin
            // Operand churn while busy must not leak into the result.
            pick_ops(x, y);
            a = x; b = y;
         end
      end
      in_valid = 1'b0;
      checks++;
      if (n_res != 4) begin
         errors++;
         $display("FAIL b2b_count got %0d exp 4", n_res);
      end
      for (int i = 1; i < acc.size(); i++) begin
         checks++;
         if (acc[i] - acc[i-1] != NBYTES + 2) begin
            errors++;
            $display("FAIL b2b_spacing_%0d got %0d exp %0d", i, acc[i] - acc[i-1], NBYTES + 2);
         end
      end
   endtask

   task automatic test_backpressure();
      logic [W-1:0] x, y;
      logic [2:0]   res, exp;
      int           lat;
      x = 32'h00FF0010; y = 32'h00FF0020;
      exp = ref_cmp(x, y);
      out_ready = 1'b0;
      run_req(x, y, res, lat);
      for (int k = 0; k < 10; k++) begin
         checks++;
         if ({out_valid, in_ready, busy, lt, eq, gt} !== {3'b101, exp}) begin
            errors++;
            $display("FAIL backpressure_hold_%0d got %b exp %b", k,
                     {out_valid, in_ready, busy, lt, eq, gt}, {3'b101, exp});
         end
         in_valid = k[0];
         a = $urandom; b = $urandom;
         @(negedge clk);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      checks++;
      if ({out_valid, in_ready, busy} !== 3'b010) begin
         errors++;
         $display("FAIL backpressure_release got %b exp 010", {out_valid, in_ready, busy});
      end
   endtask

   task automatic test_reset_mid();
      logic [2:0] res;
      int         lat;
      logic [W-1:0] x, y;
      out_ready = 1'b1;
      @(negedge clk);
      a = 32'h01020304; b = 32'h01020303; in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #2;
      checks++;
      if (busy !== 1'b1) begin
         errors++;
         $display("FAIL reset_mid_busy got %b exp 1", busy);
      end
      rst_n = 1'b0;
      #1;
      checks++;
      if ({in_ready, out_valid, lt, eq, gt, busy} !== 6'b100000) begin
         errors++;
         $display("FAIL reset_mid_run got %b exp 100000", {in_ready, out_valid, lt, eq, gt, busy});
      end
      @(negedge clk);
      rst_n = 1'b1;
      // Reset while a result is waiting in DONE.
      out_ready = 1'b0;
      run_req(32'h10, 32'h20, res, lat);
      rst_n = 1'b0;
      #1;
      checks++;
      if ({in_ready, out_valid, lt, eq, gt, busy} !== 6'b100000) begin
         errors++;
         $display("FAIL reset_in_done got %b exp 100000", {in_ready, out_valid, lt, eq, gt, busy});
      end
      @(negedge clk);
      rst_n = 1'b1;
      out_ready = 1'b1;
      x = 32'h80000000; y = 32'h7FFFFFFF;
      run_req(x, y, res, lat);
      checks++;
      if (res !== ref_cmp(x, y) || lat != NBYTES + 1) begin
         errors++;
         $display("FAIL reset_recover got %b lat %0d exp %b lat %0d", res, lat, ref_cmp(x, y), NBYTES + 1);
      end
   endtask

   task automatic test_random();
      logic [W-1:0] x, y;
      logic [2:0]   res;
      int           lat;
      out_ready = 1'b1;
      for (int i = 0; i < 40; i++) begin
         pick_ops(x, y);
         run_req(x, y, res, lat);
         checks++;
         if (res !== ref_cmp(x, y)) begin
            errors++;
            $display("FAIL random_%0d a=%h b=%h got %b exp %b", i, x, y, res, ref_cmp(x, y));
         end
         checks++;
         if (lat != NBYTES + 1) begin
            errors++;
            $display("FAIL random_%0d latency got %0d exp %0d", i, lat, NBYTES + 1);
         end
      end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_signed_vector();
      test_back_to_back();
      test_backpressure();
      test_reset_mid();
      test_random();
      repeat (2) @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/cmp_seq_ctrl.md
# cmp_seq_ctrl

Sequencing controller that compares two wide unsigned (optionally signed) operands using a single shared 8-bit cascadable magnitude comparator. It steps the comparator across the operands one byte per cycle, least-significant byte first, and feeds each byte's registered lt/eq/gt result back as the cascade input for the next byte. It sits between a requester, via a valid/ready input handshake, and a consumer, via a valid/ready result handshake.

## Interface
- NBYTES, 4: operand width in bytes; legal range 2..16.
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  reset; asynchronous, active-low.
- in_valid  input  1  request holds valid operands.
- in_ready  output  1  controller can accept a request; high only in IDLE.
- a  input  8*NBYTES  operand A; sampled only on accept.
- b  input  8*NBYTES  operand B; sampled only on accept.
- out_valid  output  1  result valid; held until accepted.
- out_ready  input  1  consumer accepts the result.
- lt  output  1  A < B; meaningful only while out_valid is high.
- eq  output  1  A == B; meaningful only while out_valid is high.
- gt  output  1  A > B; meaningful only while out_valid is high.
- busy  output  1  high in RUN and DONE.

## Operation
- Byte-comparator semantics:
  - byte A > byte B: gt=1.
  - byte A < byte B: lt=1.
  - bytes equal: pass the cascade inputs {l,e,g} to {lt,eq,gt}.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid, capture a and b into operand registers, set idx=0, set cascade register {l,e,g}={0,1,0}, go to RUN.
- RUN, each cycle:
  - Apply byte idx of both operands plus the cascade register to the comparator.
  - Register the comparator's {lt,eq,gt} into the cascade register.
  - If idx==NBYTES-1, go to DONE; otherwise idx++.
- DONE:
  - out_valid=1; lt/eq/gt drive from the cascade register and stay stable.
  - On out_ready, go to IDLE.
- Exactly one of lt/eq/gt is high in DONE.
- in_valid is ignored outside IDLE. Operand register changes are isolated from input changes after accept.
- idx is $clog2(NBYTES) bits wide and never exceeds NBYTES-1.

## Timing
- Reset values: state=IDLE, in_ready=1 (state-derived), out_valid=0, lt=0, eq=0, gt=0, busy=0, idx=0, cascade={0,1,0}.
- Accept happens at the edge where in_valid && in_ready.
- out_valid rises exactly NBYTES+1 edges after the accept edge: 1 edge to enter RUN, then NBYTES RUN cycles (the final one transitions to DONE).
- Result is consumed at the edge where out_valid && out_ready; in_ready is high the following cycle.
- Minimum request-to-request spacing is NBYTES+2 cycles.
- out_ready held high continuously: DONE lasts exactly one cycle.
- out_ready low: DONE persists indefinitely with outputs frozen.
- Reset asserted mid-RUN or in DONE: immediate return to reset values; any partial result is discarded.

## Configuration
- CMP_SEQ_SIGNED_EN defined: operands are two's complement. While idx==NBYTES-1, both operand bytes are XORed with 8'h80 before reaching the comparator; all other bytes are unchanged.
- CMP_SEQ_SIGNED_EN undefined: purely unsigned comparison with no XOR logic.

## Structure
- Shared package cmp_seq_pkg:
  - state encoding constants (IDLE=2'd0, RUN=2'd1, DONE=2'd2)
  - cascade reset constant CASCADE_INIT=3'b010 (order {l,e,g})
  - SIGN_FLIP=8'h80.
- One sub-module: cmp8_cascade, a combinational 8-bit comparator with inputs A, B, l, e, g and outputs lt, eq, gt, instantiated once.
- The byte select mux, sign-flip logic, FSM and registers live in cmp_seq_ctrl.

## Test plan
- Unsigned, NBYTES=4, out_ready=1: a=32'h12345678, b=32'h12345679 -> lt=1 eq=0 gt=0; out_valid rises exactly 5 edges after accept.
- Differing low and high bytes: a=32'hA0000001, b=32'h9FFFFFFF -> gt=1, confirming the high byte overrides the low-byte result.
- Equal operands: a=b=32'hCAFEBABE -> eq=1. Back-to-back requests are accepted at exactly 6-cycle spacing.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid rises -> outputs stable, in_ready=0, in_valid pulses ignored. Result consumed on the first out_ready cycle.
- Reset mid-operation: assert rst_n=0 two cycles after accept -> all outputs return to reset values asynchronously. After release, a new request returns the correct result.
- With CMP_SEQ_SIGNED_EN: a=32'hFFFFFFFF (-1), b=32'h00000001 -> lt=1. Without the macro, the same stimulus gives gt=1.
